// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution layer.
package conv_pkg;

    typedef enum logic {
        COMPUTE,
        DONE
    } state_t;

    localparam logic [31:0] ACT_RELU = "RELU";
    localparam logic [31:0] ACT_NONE = "NONE";

    // Full-precision accumulator width for a K x K unsigned-by-signed MAC.
    function automatic int acc_width(input int dw, input int kw, input int k);
        return dw + kw + 1 + $clog2(k * k);
    endfunction

endpackage

// File: rtl/conv_window_mac.sv
// Combinational K x K multiply-accumulate of one pixel window.
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int KDATA_WIDTH = 8,
    parameter int KERNEL_SIZE = 5,
    parameter int ACC_W       = acc_width(DATA_WIDTH, KDATA_WIDTH, KERNEL_SIZE)
) (
    input  logic [DATA_WIDTH-1:0]  win  [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
    input  logic [KDATA_WIDTH-1:0] kern [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
    output logic [ACC_W-1:0]       acc
);

    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] px;
    logic signed [ACC_W-1:0] kx;

    // Pixels zero-extend, weights sign-extend, so every product is exact.
    always_comb begin
        sum = '0;
        px  = '0;
        kx  = '0;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            for (int j = 0; j < KERNEL_SIZE; j++) begin
                px  = $signed(ACC_W'(win[i][j]));
                kx  = ACC_W'($signed(kern[i][j]));
                sum = sum + px * kx;
            end
        end
    end

    assign acc = sum;

endmodule

// File: rtl/conv_layer.sv
// Valid-mode 2-D convolution, one output per cycle in raster order.
module conv_layer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int KDATA_WIDTH = 8,
    parameter int KERNEL_SIZE = 5,
    parameter int IMGROW      = 28,
    parameter int IMGCOL      = 28,
    parameter     ACTIVATION  = "RELU",
    parameter int OUT_SHIFT   = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  image [0:IMGROW-1][0:IMGCOL-1],
    input  logic [KDATA_WIDTH-1:0] kernel [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
    output logic [DATA_WIDTH-1:0]  conv_out [0:IMGROW-KERNEL_SIZE][0:IMGCOL-KERNEL_SIZE],
    output logic                   layer_done_out
);

    localparam int K     = KERNEL_SIZE;
    localparam int OROW  = IMGROW - K + 1;
    localparam int OCOL  = IMGCOL - K + 1;
    localparam int ACC_W = acc_width(DATA_WIDTH, KDATA_WIDTH, K);
    localparam int RW    = (OROW > 1) ? $clog2(OROW) : 1;
    localparam int CW    = (OCOL > 1) ? $clog2(OCOL) : 1;
    localparam int IRW   = (IMGROW > 1) ? $clog2(IMGROW) : 1;
    localparam int ICW   = (IMGCOL > 1) ? $clog2(IMGCOL) : 1;
    localparam bit IS_RELU = (ACTIVATION == ACT_RELU);

    localparam logic [RW-1:0] RMAX = RW'(OROW - 1);
    localparam logic [CW-1:0] CMAX = CW'(OCOL - 1);

    localparam logic signed [ACC_W-1:0] UMAX = ACC_W'((1 << DATA_WIDTH) - 1);
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

    state_t state, state_nx;
    logic [RW-1:0] row, row_nx;
    logic [CW-1:0] col, col_nx;
    logic          wr_en;
    logic          done_nx;

    logic [DATA_WIDTH-1:0] win [0:K-1][0:K-1];
    logic [IRW-1:0]        ri;
    logic [ICW-1:0]        ci;

    logic [ACC_W-1:0]        acc;
    logic signed [ACC_W-1:0] acc_s;
    logic signed [ACC_W-1:0] shifted;
    logic [DATA_WIDTH-1:0]   q;

    always_comb begin
        ri = '0;
        ci = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                ri = IRW'(row) + IRW'(i);
                ci = ICW'(col) + ICW'(j);
                win[i][j] = image[ri][ci];
            end
        end
    end

    conv_window_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .KDATA_WIDTH(KDATA_WIDTH),
        .KERNEL_SIZE(K),
        .ACC_W      (ACC_W)
    ) u_mac (
        .win (win),
        .kern(kernel),
        .acc (acc)
    );

    assign acc_s   = $signed(acc);
    assign shifted = acc_s >>> OUT_SHIFT;

    always_comb begin
        q = '0;
        if (IS_RELU) begin
            if (acc_s[ACC_W-1])
                q = '0;
            else if (shifted > UMAX)
                q = '1;
            else
                q = shifted[DATA_WIDTH-1:0];
        end else begin
            if (shifted > SMAX)
                q = SMAX[DATA_WIDTH-1:0];
            else if (shifted < SMIN)
                q = SMIN[DATA_WIDTH-1:0];
            else
                q = shifted[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        state_nx = state;
        row_nx   = row;
        col_nx   = col;
        wr_en    = 1'b0;
        done_nx  = layer_done_out;
        unique case (state)
            COMPUTE: begin
                wr_en = 1'b1;
                if (col == CMAX) begin
                    col_nx = '0;
                    if (row == RMAX) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end else begin
                        row_nx = row + RW'(1);
                    end
                end else begin
                    col_nx = col + CW'(1);
                end
            end
            DONE: begin
                wr_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= COMPUTE;
            row            <= '0;
            col            <= '0;
            layer_done_out <= 1'b0;
            for (int r = 0; r < OROW; r++)
                for (int c = 0; c < OCOL; c++)
                    conv_out[r][c] <= '0;
        end else begin
            state          <= state_nx;
            row            <= row_nx;
            col            <= col_nx;
            layer_done_out <= done_nx;
            if (wr_en)
                conv_out[row][col] <= q;
        end
    end

endmodule

// File: tb/tb_conv_layer.sv
// Directed bench for conv_layer: RELU, NONE and a small 7x7/K=3 instance.
module tb_conv_layer;

    logic dut_clk = 1'b0;
    logic rst = 1'b1;

    always #5 dut_clk = ~dut_clk;

    logic [7:0] image    [0:27][0:27];
    logic [7:0] kernel   [0:4][0:4];
    logic [7:0] out_relu [0:23][0:23];
    logic [7:0] out_none [0:23][0:23];
    logic       done_relu;
    logic       done_none;

    logic [7:0] image_s  [0:6][0:6];
    logic [7:0] kernel_s [0:2][0:2];
    logic [7:0] out_s    [0:4][0:4];
    logic       done_s;

    int checks = 0;
    int errors = 0;

    conv_layer u_relu (
        .clk           (dut_clk),
        .rst           (rst),
        .image         (image),
        .kernel        (kernel),
        .conv_out      (out_relu),
        .layer_done_out(done_relu)
    );

    conv_layer #(.ACTIVATION("NONE")) u_none (
        .clk           (dut_clk),
        .rst           (rst),
        .image         (image),
        .kernel        (kernel),
        .conv_out      (out_none),
        .layer_done_out(done_none)
    );

    conv_layer #(.IMGROW(7), .IMGCOL(7), .KERNEL_SIZE(3)) u_small (
        .clk           (dut_clk),
        .rst           (rst),
        .image         (image_s),
        .kernel        (kernel_s),
        .conv_out      (out_s),
        .layer_done_out(done_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge dut_clk);
        #1;
    endtask

    task automatic fill_img(input logic [7:0] v);
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                image[r][c] = v;
    endtask

    task automatic fill_kern(input logic [7:0] v);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                kernel[r][c] = v;
    endtask

    function automatic int count_bad(input bit use_none, input bit raster, input logic [7:0] v);
        int n = 0;
        logic [7:0] e;
        logic [7:0] o;
        for (int r = 0; r < 24; r++) begin
            for (int c = 0; c < 24; c++) begin
                e = raster ? 8'(c) : v;
                o = use_none ? out_none[r][c] : out_relu[r][c];
                if (o !== e)
                    n++;
            end
        end
        return n;
    endfunction

    function automatic int count_bad_s(input logic [7:0] v);
        int n = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                if (out_s[r][c] !== v)
                    n++;
        return n;
    endfunction

    task automatic reset_dut(input string tag);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check({tag, "_rst_done_relu"}, 32'(done_relu), 0);
        check({tag, "_rst_done_none"}, 32'(done_none), 0);
        check({tag, "_rst_zero"}, 32'(count_bad(1'b0, 1'b0, 8'd0)), 0);
    endtask

    task automatic finish_pass(input string tag, input int edges_done);
        tick(575 - edges_done);
        check({tag, "_done_early_relu"}, 32'(done_relu), 0);
        check({tag, "_done_early_none"}, 32'(done_none), 0);
        tick(1);
        check({tag, "_done_relu"}, 32'(done_relu), 1);
        check({tag, "_done_none"}, 32'(done_none), 1);
    endtask

    initial begin
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++)
                image_s[r][c] = 8'd1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                kernel_s[r][c] = 8'h10;

        // Scaling: 200 * 0x40 >> 7 = 100; small instance finishes at edge 25.
        fill_img(8'd200);
        fill_kern(8'h00);
        kernel[2][2] = 8'h40;
        reset_dut("scale");
        check("small_rst_done", 32'(done_s), 0);
        tick(24);
        check("small_done_early", 32'(done_s), 0);
        tick(1);
        check("small_done", 32'(done_s), 1);
        check("small_vals", 32'(count_bad_s(8'd1)), 0);
        finish_pass("scale", 25);
        check("scale_relu_vals", 32'(count_bad(1'b0, 1'b0, 8'd100)), 0);
        check("scale_none_vals", 32'(count_bad(1'b1, 1'b0, 8'd100)), 0);
        tick(10);
        check("scale_done_sticky", 32'(done_relu), 1);
        check("scale_hold_vals", 32'(count_bad(1'b0, 1'b0, 8'd100)), 0);
        check("small_done_sticky", 32'(done_s), 1);

        // Raster order: conv_out[j][i] = i.
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                image[r][c] = 8'(2 * c);
        fill_kern(8'h00);
        kernel[0][0] = 8'h40;
        reset_dut("raster");
        tick(25);
        check("raster_e25_last_row0", 32'(out_relu[0][23]), 23);
        check("raster_e25_unwritten", 32'(out_relu[1][1]), 0);
        tick(1);
        check("raster_e26_written", 32'(out_relu[1][1]), 1);
        finish_pass("raster", 26);
        check("raster_relu_vals", 32'(count_bad(1'b0, 1'b1, 8'd0)), 0);
        check("raster_none_vals", 32'(count_bad(1'b1, 1'b1, 8'd0)), 0);

        // Negative accumulator: -250.
        fill_img(8'd10);
        fill_kern(8'hFF);
        reset_dut("neg");
        finish_pass("neg", 0);
        check("neg_relu_vals", 32'(count_bad(1'b0, 1'b0, 8'h00)), 0);
        check("neg_none_vals", 32'(count_bad(1'b1, 1'b0, 8'hFE)), 0);

        // Positive saturation.
        fill_img(8'd255);
        fill_kern(8'h7F);
        reset_dut("satp");
        finish_pass("satp", 0);
        check("satp_relu_vals", 32'(count_bad(1'b0, 1'b0, 8'd255)), 0);
        check("satp_none_vals", 32'(count_bad(1'b1, 1'b0, 8'h7F)), 0);

        // Negative saturation.
        fill_kern(8'h80);
        reset_dut("satn");
        finish_pass("satn", 0);
        check("satn_relu_vals", 32'(count_bad(1'b0, 1'b0, 8'h00)), 0);
        check("satn_none_vals", 32'(count_bad(1'b1, 1'b0, 8'h80)), 0);

        // Reset asserted for edge 100 of a pass.
        fill_kern(8'h7F);
        reset_dut("mid");
        tick(99);
        check("mid_before_rst", 32'(out_relu[4][2]), 255);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_done", 32'(done_relu), 0);
        check("mid_rst_zero", 32'(count_bad(1'b0, 1'b0, 8'd0)), 0);
        check("mid_rst_elem", 32'(out_relu[0][0]), 0);
        finish_pass("mid", 0);
        check("mid_relu_vals", 32'(count_bad(1'b0, 1'b0, 8'd255)), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
